// File: rtl/stage_mem_pkg.sv
// Shared pipeline package: execute-stage ALU/status constants plus
// memory-stage state type, address base and wait-counter width.
package stage_mem_pkg;

    // ALU commands produced by stage_ex
    localparam logic [3:0] ALU_MOV = 4'b0001;
    localparam logic [3:0] ALU_MVN = 4'b1001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_ADC = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SBC = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b0110;
    localparam logic [3:0] ALU_ORR = 4'b0111;
    localparam logic [3:0] ALU_EOR = 4'b1000;

    // Status register bit positions
    localparam int STATUS_N = 3;
    localparam int STATUS_Z = 2;
    localparam int STATUS_C = 1;
    localparam int STATUS_V = 0;

    localparam logic [31:0] ADDR_BASE_DEF = 32'd1024;
    localparam int          WAIT_W        = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } mem_state_t;

endpackage

// File: rtl/stage_mem_if.sv
// Execute-to-memory bundle. master = execute side (drives the *In
// fields), slave = memory stage (drives pass-throughs, memData, ready).
interface stage_mem_if;

    logic        wbEnIn;
    logic        memREnIn;
    logic        memWEnIn;
    logic [31:0] aluRes;
    logic [31:0] valRm;
    logic [3:0]  dest;
    logic        wbEnOut;
    logic        memREnOut;
    logic [31:0] aluResOut;
    logic [3:0]  memDest;
    logic [31:0] memData;
    logic        ready;

    modport master (
        output wbEnIn, memREnIn, memWEnIn,
        output aluRes, valRm, dest,
        input  wbEnOut, memREnOut, aluResOut,
        input  memDest, memData, ready
    );

    modport slave (
        input  wbEnIn, memREnIn, memWEnIn,
        input  aluRes, valRm, dest,
        output wbEnOut, memREnOut, aluResOut,
        output memDest, memData, ready
    );

endinterface

// File: rtl/stage_mem_data_memory.sv
// Word array: synchronous write, combinational read, cleared on reset.
// Ports: clk, rst, we, idx, wdata in; rdata out.
module data_memory #(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/stage_mem.sv
// Memory stage: fixed-latency load/store into data_memory, holds ready
// low while an access is in flight. Ports: clk, rst, bus (slave).
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF,
    parameter int          WAIT_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    stage_mem_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
    localparam logic [WAIT_W-1:0] CNT_INIT =
        WAIT_W'(WAIT_CYCLES - 1);

    mem_state_t        state;
    mem_state_t        stateNext;
    logic [WAIT_W-1:0] counter;
    logic [31:0]       off;
    logic [31:0]       rdata;
    logic [31:0]       loadData;
    logic [IDX_W-1:0]  idx;
    logic              req;
    logic              inRange;
    logic              doAccess;
    logic              memWe;

    assign bus.wbEnOut   = bus.wbEnIn;
    assign bus.memREnOut = bus.memREnIn;
    assign bus.aluResOut = bus.aluRes;
    assign bus.memDest   = bus.dest;
    assign bus.memData   = loadData;

    assign req = bus.memREnIn | bus.memWEnIn;

    // Unsigned subtract: addresses below the base wrap high and fail
    // the range test; low two bits dropped to force word alignment.
    assign off     = bus.aluRes - ADDR_BASE;
    assign inRange = off < SPAN;
    assign idx     = off[IDX_W+1:2];

    // The request cycle in IDLE is the first low cycle, so ACCESS
    // finishes on the edge where counter steps from 1 to 0.
    always_comb begin
        stateNext = state;
        bus.ready = 1'b1;
        doAccess  = 1'b0;
        unique case (state)
            IDLE: begin
                bus.ready = ~req;
                if (req) begin
                    if (WAIT_CYCLES == 1) begin
                        doAccess  = 1'b1;
                        stateNext = DONE;
                    end else begin
                        stateNext = ACCESS;
                    end
                end
            end
            ACCESS: begin
                bus.ready = 1'b0;
                if (counter == WAIT_W'(1)) begin
                    doAccess  = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        if (rst) begin
            bus.ready = 1'b1;
        end
    end

    assign memWe = doAccess & bus.memWEnIn & inRange;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            counter  <= '0;
            loadData <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && req) begin
                counter <= CNT_INIT;
            end else if (state == ACCESS && counter != '0) begin
                counter <= counter - 1'b1;
            end
            if (doAccess && !bus.memWEnIn) begin
                loadData <= inRange ? rdata : '0;
            end
        end
    end

    data_memory #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) uMem (
        .clk   (clk),
        .rst   (rst),
        .we    (memWe),
        .idx   (idx),
        .wdata (bus.valRm),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: per-instruction latency/data model for a
// WAIT_CYCLES=3 build plus a directed WAIT_CYCLES=1 build.
module tb_stage_mem;

    localparam int W = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    stage_mem_if bus3 ();
    stage_mem_if bus1 ();

    stage_mem #(
        .DEPTH_WORDS (64),
        .ADDR_BASE   (32'd1024),
        .WAIT_CYCLES (W)
    ) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    stage_mem #(
        .DEPTH_WORDS (64),
        .ADDR_BASE   (32'd1024),
        .WAIT_CYCLES (1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Model: the instruction currently held on bus3 and how many
    // cycles it has been held; memory and last load value.
    logic [31:0] modelMem [64];
    logic [31:0] modelData;
    bit          curRd, curWr, curWb;
    logic [31:0] curAddr, curVal;
    logic [3:0]  curDest;
    int          cyc;
    bit          checkOn;
    bit          isMem;
    bit          expReady;

    function automatic bit inRng(input logic [31:0] a);
        logic [31:0] o;
        o = a - 32'd1024;
        return o < 32'd256;
    endfunction

    function automatic int wordOf(input logic [31:0] a);
        logic [31:0] o;
        o = (a - 32'd1024) / 32'd4;
        return int'(o);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 64; i++) modelMem[i] = '0;
        modelData = '0;
    endtask

    // A memory instruction is held W+1 cycles; only the last is ready.
    always @(negedge clk) begin
        if (checkOn && !rst) begin
            isMem    = curRd | curWr;
            expReady = !isMem || cyc == W;
            if (isMem && cyc == W) begin
                if (curWr) begin
                    if (inRng(curAddr))
                        modelMem[wordOf(curAddr)] = curVal;
                end else begin
                    modelData = inRng(curAddr) ?
                        modelMem[wordOf(curAddr)] : 32'd0;
                end
            end
            check("ready", 32'(bus3.ready), 32'(expReady));
            check("memData", bus3.memData, modelData);
            check("aluResOut", bus3.aluResOut, curAddr);
            check("memDest", 32'(bus3.memDest), 32'(curDest));
            check("wbEnOut", 32'(bus3.wbEnOut), 32'(curWb));
            check("memREnOut", 32'(bus3.memREnOut), 32'(curRd));
            cyc++;
        end
    end

    task automatic drive3(input bit rd, input bit wr, input bit wb,
                          input logic [31:0] a,
                          input logic [31:0] v,
                          input logic [3:0] d);
        bus3.memREnIn = rd;
        bus3.memWEnIn = wr;
        bus3.wbEnIn   = wb;
        bus3.aluRes   = a;
        bus3.valRm    = v;
        bus3.dest     = d;
        curRd   = rd;
        curWr   = wr;
        curWb   = wb;
        curAddr = a;
        curVal  = v;
        curDest = d;
        cyc     = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the instruction.
    task automatic issue(input bit rd, input bit wr, input bit wb,
                         input logic [31:0] a,
                         input logic [31:0] v,
                         input logic [3:0] d);
        drive3(rd, wr, wb, a, v, d);
        repeat ((rd | wr) ? W + 1 : 1) @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] v);
        issue(1'b0, 1'b1, 1'b0, a, v, 4'd2);
    endtask

    task automatic ld(input logic [31:0] a);
        issue(1'b1, 1'b0, 1'b1, a, 32'h0, 4'd3);
    endtask

    task automatic nop();
        issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    endtask

    task automatic issue1(input bit rd, input bit wr,
                          input logic [31:0] a,
                          input logic [31:0] v,
                          input logic [31:0] expData);
        bus1.memREnIn = rd;
        bus1.memWEnIn = wr;
        bus1.aluRes   = a;
        bus1.valRm    = v;
        @(negedge clk);
        check("w1 ready low", 32'(bus1.ready), 32'd0);
        @(negedge clk);
        check("w1 ready high", 32'(bus1.ready), 32'd1);
        check("w1 memData", bus1.memData, expData);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        checkOn = 1'b0;
        modelReset();
        drive3(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        bus1.wbEnIn   = 1'b0;
        bus1.memREnIn = 1'b0;
        bus1.memWEnIn = 1'b0;
        bus1.aluRes   = '0;
        bus1.valRm    = '0;
        bus1.dest     = '0;
        rst = 1'b1;
        #3;
        check("rst ready w/ req", 32'(bus3.ready), 32'd1);
        check("rst memData", bus3.memData, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive3(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        checkOn = 1'b1;
        nop();

        st(32'd1024, 32'hDEADBEEF);
        check("store keeps memData", bus3.memData, 32'd0);
        ld(32'd1024);
        check("load 1024", bus3.memData, 32'hDEADBEEF);

        st(32'd1027, 32'h11111111);
        ld(32'd1024);
        check("misaligned store", bus3.memData, 32'h11111111);

        st(32'd1024 + 32'd252, 32'h12345678);
        ld(32'd1024 + 32'd252);
        check("last word", bus3.memData, 32'h12345678);

        repeat (3) issue(1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 4'd7);
        check("nonmem memData", bus3.memData, 32'h12345678);

        issue(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0A0B0C0D, 4'd1);
        check("rd+wr is store", bus3.memData, 32'h12345678);
        ld(32'd1032);
        check("rd+wr data", bus3.memData, 32'h0A0B0C0D);

        st(32'd1024 + 32'd256, 32'hBAD0BAD0);
        st(32'd1020, 32'hBAD1BAD1);
        st(32'hFFFF_FFFC, 32'hBAD2BAD2);
        for (int i = 0; i < 64; i++) ld(32'd1024 + 32'(4 * i));
        check("scan word63", bus3.memData, 32'h12345678);

        ld(32'd1020);
        check("oor load", bus3.memData, 32'd0);

        ld(32'd1024);
        drive3(1'b0, 1'b1, 1'b0, 32'd1028, 32'hCAFEF00D, 4'd4);
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOn = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst ready", 32'(bus3.ready), 32'd1);
        check("midrst memData", bus3.memData, 32'd0);
        drive3(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOn = 1'b1;
        cyc = 0;
        nop();
        ld(32'd1028);
        check("abandoned store", bus3.memData, 32'd0);
        nop();
        checkOn = 1'b0;

        issue1(1'b0, 1'b1, 32'd1024, 32'hA5A5A5A5, 32'd0);
        issue1(1'b0, 1'b1, 32'd1028, 32'h5A5A5A5A, 32'd0);
        issue1(1'b1, 1'b0, 32'd1024, 32'h0, 32'hA5A5A5A5);
        issue1(1'b1, 1'b0, 32'd1028, 32'h0, 32'h5A5A5A5A);
        bus1.memREnIn = 1'b0;
        @(negedge clk);
        check("w1 idle ready", 32'(bus1.ready), 32'd1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
